// File: rtl/pmem_loader_pkg.sv
// rtl/pmem_loader_pkg.sv - shared types and constants for the program-memory loader
//
// Purpose: FSM state encoding, default widths and stream-format constants
// shared by pmem_loader and its checksum helper.

package pmem_loader_pkg;

    localparam int unsigned DEFAULT_ADDR_W  = 8;
    localparam int unsigned DEFAULT_INSTR_W = 12;

    // Every stream element is one byte; an instruction is a {hi, lo} byte pair
    // with lo supplying the low BYTE_W bits of the instruction.
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CNT,
        ST_LO,
        ST_HI,
        ST_WR,
        ST_CHK,
        ST_DONE
    } state_e;

endpackage

// File: rtl/pmem_loader_csum.sv
// rtl/pmem_loader_csum.sv - 8-bit XOR accumulator over the load stream
//
// Purpose: running XOR of every byte accepted in a session.
// Ports:
//   clk_i   in   clock
//   rst_i   in   asynchronous active-high reset
//   clear_i in   zero the accumulator (has priority over en_i)
//   en_i    in   fold data_i into the accumulator
//   data_i  in   8-bit byte
//   acc_o   out  current accumulator value

module pmem_loader_csum
    import pmem_loader_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              en_i,
    input  logic [BYTE_W-1:0] data_i,
    output logic [BYTE_W-1:0] acc_o
);

    logic [BYTE_W-1:0] acc_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else if (clear_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_q ^ data_i;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/pmem_loader.sv
// rtl/pmem_loader.sv - packs a byte stream into instructions and loads program memory
//
// Purpose: session = count byte N (0 means 2^ADDR_W), then N {lo, hi} pairs;
// each pair becomes one instruction written at auto-incrementing addresses.
// Optional feature macro: PMEM_LOADER_CHECKSUM_EN (trailing XOR checksum byte).
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   start                  session start pulse (ignored while busy)
//   rx_data/rx_valid/rx_ready   byte stream, accepted on rx_valid && rx_ready
//   LoadE/LoadAddr/LoadInstruction   memory load port, one-cycle strobe per word
//   busy, cpu_hold         session active (identical)
//   done                   one-cycle pulse at session end
//   err                    sticky checksum error (0 when the checksum is disabled)

module pmem_loader
    import pmem_loader_pkg::*;
#(
    parameter int unsigned       ADDR_W    = DEFAULT_ADDR_W,
    parameter int unsigned       INSTR_W   = DEFAULT_INSTR_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [BYTE_W-1:0]  rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic               LoadE,
    output logic [ADDR_W-1:0]  LoadAddr,
    output logic [INSTR_W-1:0] LoadInstruction,
    output logic               busy,
    output logic               cpu_hold,
    output logic               done,
    output logic               err
);

    state_e             state_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W-1:0]  remaining_q;
    logic [BYTE_W-1:0]  lo_q;
    logic               rx_ready_q;
    logic               load_e_q;
    logic [ADDR_W-1:0]  load_addr_q;
    logic [INSTR_W-1:0] load_instr_q;
    logic               busy_q;
    logic               done_q;
    logic               accept;

    // rx_ready_q is only ever 1 in CNT, LO, HI and CHK, so it doubles as the
    // state qualifier for a byte acceptance.
    assign accept = rx_valid && rx_ready_q;

`ifdef PMEM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] csum;
    logic              err_q;

    pmem_loader_csum u_csum (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (state_q == ST_IDLE && start),
        .en_i    (accept && state_q != ST_CHK),
        .data_i  (rx_data),
        .acc_o   (csum)
    );

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            remaining_q  <= '0;
            lo_q         <= '0;
            rx_ready_q   <= 1'b0;
            load_e_q     <= 1'b0;
            load_addr_q  <= '0;
            load_instr_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef PMEM_LOADER_CHECKSUM_EN
            err_q        <= 1'b0;
`endif
        end else begin
            load_e_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q    <= ST_CNT;
                        busy_q     <= 1'b1;
                        rx_ready_q <= 1'b1;
`ifdef PMEM_LOADER_CHECKSUM_EN
                        err_q      <= 1'b0;
`endif
                    end
                end
                ST_CNT: begin
                    if (accept) begin
                        // N = 0 loads 0; the counter then runs through all
                        // 2^ADDR_W values before reaching the final word.
                        remaining_q <= ADDR_W'(rx_data);
                        addr_q      <= BASE_ADDR;
                        state_q     <= ST_LO;
                    end
                end
                ST_LO: begin
                    if (accept) begin
                        lo_q    <= rx_data;
                        state_q <= ST_HI;
                    end
                end
                ST_HI: begin
                    if (accept) begin
                        load_e_q     <= 1'b1;
                        load_addr_q  <= addr_q;
                        load_instr_q <= {rx_data[INSTR_W-BYTE_W-1:0], lo_q};
                        rx_ready_q   <= 1'b0;
                        state_q      <= ST_WR;
                    end
                end
                ST_WR: begin
                    addr_q      <= addr_q + ADDR_W'(1);
                    remaining_q <= remaining_q - ADDR_W'(1);
                    if (remaining_q != ADDR_W'(1)) begin
                        rx_ready_q <= 1'b1;
                        state_q    <= ST_LO;
                    end else begin
`ifdef PMEM_LOADER_CHECKSUM_EN
                        rx_ready_q <= 1'b1;
                        state_q    <= ST_CHK;
`else
                        done_q     <= 1'b1;
                        state_q    <= ST_DONE;
`endif
                    end
                end
`ifdef PMEM_LOADER_CHECKSUM_EN
                ST_CHK: begin
                    if (accept) begin
                        if ((csum ^ rx_data) != '0) begin
                            err_q <= 1'b1;
                        end
                        rx_ready_q <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    rx_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign rx_ready        = rx_ready_q;
    assign LoadE           = load_e_q;
    assign LoadAddr        = load_addr_q;
    assign LoadInstruction = load_instr_q;
    assign busy            = busy_q;
    assign cpu_hold        = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_pmem_loader.sv
// tb/tb_pmem_loader.sv - self-checking bench for pmem_loader

module tb_pmem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        LoadE;
    logic [7:0]  LoadAddr;
    logic [11:0] LoadInstruction;
    logic        busy;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pmem_loader #(
        .ADDR_W    (8),
        .INSTR_W   (12),
        .BASE_ADDR (8'h00)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_ready        (rx_ready),
        .LoadE           (LoadE),
        .LoadAddr        (LoadAddr),
        .LoadInstruction (LoadInstruction),
        .busy            (busy),
        .cpu_hold        (cpu_hold),
        .done            (done),
        .err             (err)
    );

    typedef struct packed {
        logic [7:0]  a;
        logic [11:0] d;
    } wr_t;

    wr_t exp_q[$];
    wr_t log_q[$];
    wr_t w_pop;
    int  done_cnt   = 0;
    int  cyc        = 0;
    int  start_cyc  = 0;
    int  done_cyc   = 0;
    bit  exp_err    = 1'b0;
    bit  in_session = 1'b0;
    bit  prev_loade = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Compare process: checks every write against the expected-write queue.
    always @(negedge clk) begin
        if (rst) begin
            prev_loade = 1'b0;
        end else begin
            chk("cpu_hold_eq_busy", cpu_hold, busy);
            if (!busy) chk("rx_ready_when_idle", rx_ready, 0);
            if (in_session) chk("busy_in_session", busy, 1);
            if (LoadE) begin
                chk("loade_single_cycle", prev_loade, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual=%h/%h required=none", LoadAddr, LoadInstruction);
                end else begin
                    w_pop = exp_q.pop_front();
                    chk("load_addr", LoadAddr, w_pop.a);
                    chk("load_instr", LoadInstruction, w_pop.d);
                end
                log_q.push_back({LoadAddr, LoadInstruction});
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_after_last_write", exp_q.size(), 0);
                chk("err_at_done", err, exp_err);
            end
            prev_loade = LoadE;
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        start_cyc  = cyc;
        in_session = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit acc = 1'b0;
        int guard = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!acc && guard < 200) begin
            acc = rx_ready;
            @(posedge clk); #1;
            guard++;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL byte_accept_timeout actual=not_accepted required=accepted byte=%h", b);
        end
    endtask

    task automatic wait_done();
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        in_session = 1'b0;
        if (done_cnt == d0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=no_done required=done");
        end
        @(posedge clk); #1;
        chk("busy_drops_after_done", busy, 0);
        @(posedge clk); #1;
        chk("done_once", done_cnt, d0 + 1);
    endtask

    // Model: expected writes are the pairs in order at addresses 0,1,2,...
    task automatic run_session(input logic [7:0] b_in[$], input bit gap, input bit poke, input bit bad_c);
        logic [7:0] b[$];
        logic [7:0] x;
        logic [7:0] lo, hi, a;
        int words;
        b = b_in;
        words = (b[0] == 8'h00) ? 256 : int'(b[0]);
        x = 8'h00;
        foreach (b[i]) x ^= b[i];
`ifdef PMEM_LOADER_CHECKSUM_EN
        b.push_back(bad_c ? 8'h00 : x);
        exp_err = bad_c && (x != 8'h00);
`else
        exp_err = 1'b0;
`endif
        log_q.delete();
        for (int i = 0; i < words; i++) begin
            lo = b[1 + 2 * i];
            hi = b[2 + 2 * i];
            a  = i[7:0];
            exp_q.push_back({a, hi[3:0], lo});
        end
        do_start();
        foreach (b[i]) begin
            send_byte(b[i]);
            if (i > 0 && i <= 2 * words && i % 2 == 0) chk("loade_after_hi", LoadE, 1);
            if (poke && i == 1) begin
                rx_valid = 1'b0;
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
            if (gap) begin
                rx_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        rx_valid = 1'b0;
        wait_done();
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_rx_ready"}, rx_ready, 0);
        chk({tag, "_LoadE"}, LoadE, 0);
        chk({tag, "_LoadAddr"}, LoadAddr, 0);
        chk({tag, "_LoadInstruction"}, LoadInstruction, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_cpu_hold"}, cpu_hold, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] s[$];
        rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        #12;
        check_outputs_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: basic two-word load
        s = '{8'h02, 8'h34, 8'h0A, 8'hCD, 8'hF1};
        run_session(s, 1'b0, 1'b0, 1'b0);
        chk("t1_writes", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("t1_w0", log_q[0], {8'h00, 12'hA34});
            chk("t1_w1", log_q[1], {8'h01, 12'h1CD});
        end
`ifdef PMEM_LOADER_CHECKSUM_EN
        chk("t1_start_to_done_cycles", done_cyc - start_cyc, 8);
`else
        chk("t1_start_to_done_cycles", done_cyc - start_cyc, 7);
`endif
        chk("t1_err", err, 0);

        // 2: rx_valid toggling during a 3-word load
        s = '{8'h03, 8'h11, 8'h02, 8'h22, 8'hF3, 8'h33, 8'hA4};
        run_session(s, 1'b1, 1'b0, 1'b0);
        chk("t2_writes", log_q.size(), 3);
        if (log_q.size() == 3) chk("t2_w2", log_q[2], {8'h02, 12'h433});

        // 3: count byte 0 -> 256 words, address runs to FF
        s = '{8'h00};
        for (int i = 0; i < 256; i++) begin
            s.push_back(i[7:0]);
            s.push_back(~i[7:0]);
        end
        run_session(s, 1'b0, 1'b0, 1'b0);
        chk("t3_writes", log_q.size(), 256);
        if (log_q.size() == 256) begin
            chk("t3_first", log_q[0], {8'h00, 12'hF00});
            chk("t3_last", log_q[255], {8'hFF, 12'h0FF});
        end

        // 4: reset after the lo byte of word 2 of 4
        log_q.delete();
        exp_q.push_back({8'h00, 12'h5AB});
        exp_err = 1'b0;
        do_start();
        send_byte(8'h04); send_byte(8'hAB); send_byte(8'h05); send_byte(8'hCD);
        rx_valid = 1'b0;
        in_session = 1'b0;
        rst = 1'b1;
        #1;
        check_outputs_zero("midreset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("t4_exp_drained", exp_q.size(), 0);
        chk("t4_writes_before_reset", log_q.size(), 1);
        s = '{8'h02, 8'h34, 8'h0A, 8'hCD, 8'hF1};
        run_session(s, 1'b0, 1'b0, 1'b0);
        if (log_q.size() > 0) chk("t4_fresh_addr", log_q[0].a, 8'h00);

        // 5: bytes in IDLE are refused; start while busy is ignored
        log_q.delete();
        rx_data = 8'h02; rx_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t5_idle_rx_ready", rx_ready, 0);
            chk("t5_idle_busy", busy, 0);
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        chk("t5_idle_writes", log_q.size(), 0);
        s = '{8'h02, 8'h55, 8'h07, 8'h66, 8'h08};
        run_session(s, 1'b0, 1'b1, 1'b0);
        chk("t5_writes", log_q.size(), 2);
        if (log_q.size() == 2) chk("t5_w1", log_q[1], {8'h01, 12'h866});

`ifdef PMEM_LOADER_CHECKSUM_EN
        // 6: checksum good (3F) then bad (00), then err clears on next start
        s = '{8'h01, 8'h34, 8'h0A};
        run_session(s, 1'b0, 1'b0, 1'b0);
        chk("t6_err_good", err, 0);
        run_session(s, 1'b0, 1'b0, 1'b1);
        chk("t6_err_bad", err, 1);
        do_start();
        chk("t6_err_cleared", err, 0);
        in_session = 1'b0;
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
`endif

        @(posedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
